// File: rtl/sar_pkg.sv
// Shared types, limits and width helpers for the SAR ADC controller.
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned N_MIN        = 2;
  localparam int unsigned N_MAX        = 16;
  localparam int unsigned CHANNELS_MIN = 1;
  localparam int unsigned CHANNELS_MAX = 16;
  localparam int unsigned SETTLE_MAX   = 15;

  // Settle counter width, sized to hold SETTLE_MAX.
  localparam int unsigned WAIT_W = 4;

  // Channel index width: at least one bit, even for a single channel.
  function automatic int unsigned cw_of(input int unsigned channels);
    int unsigned w;
    w = $clog2(channels);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sar_core.sv
// Single-channel N-bit successive-approximation engine.
module sar_core
  import sar_pkg::*;
#(
  parameter int unsigned N      = 8,
  parameter int unsigned SETTLE = 1
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         start,
  input  logic         digit,
  output logic [N-1:0] code,
  output logic         done_c,
  output logic [N-1:0] final_c
);

  localparam int unsigned IW = $clog2(N);
  localparam logic [N-1:0] MSB_ONLY = {1'b1, {(N-1){1'b0}}};
  localparam logic [IW-1:0] INDEX_TOP = IW'(N - 1);
  localparam logic [WAIT_W-1:0] SETTLE_CNT = WAIT_W'(SETTLE);

  logic [IW-1:0]     index;
  logic [WAIT_W-1:0] wait_cnt;
  logic              busy;
  logic [N-1:0]      decide_code;

  // Decide step: keep the tried bit per comparator, try the next lower bit.
  always_comb begin
    decide_code = code;
    decide_code[index] = digit;
    if (index != '0) begin
      decide_code[index - IW'(1)] = 1'b1;
    end
    done_c  = busy && (wait_cnt == '0) && (index == '0);
    final_c = decide_code;
  end

  // Code, bit index and settle counter; start restarts from MSB-only.
  always_ff @(posedge clock) begin
    if (!reset_) begin
      code     <= '0;
      index    <= '0;
      wait_cnt <= '0;
      busy     <= 1'b0;
    end else if (start) begin
      code     <= MSB_ONLY;
      index    <= INDEX_TOP;
      wait_cnt <= SETTLE_CNT;
      busy     <= 1'b1;
    end else if (busy) begin
      if (wait_cnt != '0) begin
        wait_cnt <= wait_cnt - WAIT_W'(1);
      end else begin
        code <= decide_code;
        if (index != '0) begin
          index    <= index - IW'(1);
          wait_cnt <= SETTLE_CNT;
        end else begin
          busy <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/sar_adc_controller.sv
// SAR ADC controller: soc/eoc handshake, channel sequencing, result registers.
module sar_adc_controller
  import sar_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SETTLE   = 1,
  localparam int unsigned CW      = cw_of(CHANNELS)
) (
  input  logic          clock,
  input  logic          reset_,
  input  logic          soc,
  input  logic          scan,
  input  logic [CW-1:0] chan_sel,
  input  logic          digit,
  output logic [N-1:0]  dac_code,
  output logic [CW-1:0] mux_sel,
  output logic          eoc,
  output logic [N-1:0]  result,
  output logic [CW-1:0] result_chan,
  output logic          result_valid
);

  localparam logic [CW-1:0] LAST_CHAN = CW'(CHANNELS - 1);

  state_t        state;
  logic          scan_q;
  logic [CW-1:0] start_chan_c;
  logic          more_chan_c;
  logic          core_start_c;
  logic          core_done_c;
  logic [N-1:0]  core_final_c;

  // Start channel selection and core restart for the next scan channel.
  always_comb begin
    start_chan_c = chan_sel;
    if (32'(chan_sel) >= CHANNELS) begin
      start_chan_c = LAST_CHAN;
    end
    if (scan) begin
      start_chan_c = '0;
    end
    more_chan_c  = scan_q && (mux_sel != LAST_CHAN);
    core_start_c = ((state == IDLE) && soc) ||
                   ((state == CONV) && core_done_c && more_chan_c);
  end

  sar_core #(
    .N      (N),
    .SETTLE (SETTLE)
  ) u_core (
    .clock   (clock),
    .reset_  (reset_),
    .start   (core_start_c),
    .digit   (digit),
    .code    (dac_code),
    .done_c  (core_done_c),
    .final_c (core_final_c)
  );

  // Handshake FSM with mode latch, channel counter and result capture.
  always_ff @(posedge clock) begin
    if (!reset_) begin
      state        <= IDLE;
      scan_q       <= 1'b0;
      mux_sel      <= '0;
      eoc          <= 1'b1;
      result       <= '0;
      result_chan  <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (soc) begin
            scan_q  <= scan;
            mux_sel <= start_chan_c;
            eoc     <= 1'b0;
            state   <= CONV;
          end else begin
            eoc <= 1'b1;
          end
        end
        CONV: begin
          if (core_done_c) begin
            result       <= core_final_c;
            result_chan  <= mux_sel;
            result_valid <= 1'b1;
            if (more_chan_c) begin
              mux_sel <= mux_sel + CW'(1);
            end else begin
              state <= DONE;
              eoc   <= 1'b1;
            end
          end
        end
        DONE: begin
          if (!soc) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_adc_controller.sv
// Scoreboard bench for sar_adc_controller with a binary-search reference model.
module tb_sar_adc_controller;

  localparam int NB  = 8;
  localparam int CH  = 4;
  localparam int S   = 1;
  localparam int N2  = 10;
  localparam int CH2 = 3;
  localparam int S2  = 3;

  logic clock = 1'b0;
  logic reset_ = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Default-parameter DUT
  logic          soc = 1'b0, scan = 1'b0;
  logic [1:0]    chan_sel = '0;
  logic          digit;
  logic [NB-1:0] dac_code, result;
  logic [1:0]    mux_sel, result_chan;
  logic          eoc, result_valid;
  logic [NB-1:0] tgt [CH];

  assign digit = (tgt[mux_sel] >= dac_code);

  sar_adc_controller dut (
    .clock(clock), .reset_(reset_), .soc(soc), .scan(scan), .chan_sel(chan_sel),
    .digit(digit), .dac_code(dac_code), .mux_sel(mux_sel), .eoc(eoc),
    .result(result), .result_chan(result_chan), .result_valid(result_valid)
  );

  // Wide, slow-settling DUT with three channels
  logic          soc2 = 1'b0, scan2 = 1'b0;
  logic [1:0]    chan2 = '0;
  logic          digit2 = 1'b0;
  logic [N2-1:0] dac2, res2;
  logic [1:0]    mux2, rch2;
  logic          eoc2, rv2;
  logic [N2-1:0] tgt2 [CH2];

  sar_adc_controller #(.N(N2), .CHANNELS(CH2), .SETTLE(S2)) dut2 (
    .clock(clock), .reset_(reset_), .soc(soc2), .scan(scan2), .chan_sel(chan2),
    .digit(digit2), .dac_code(dac2), .mux_sel(mux2), .eoc(eoc2),
    .result(res2), .result_chan(rch2), .result_valid(rv2)
  );

  typedef struct {
    logic [NB-1:0] res;
    logic [1:0]    ch;
    int            t;
    bit            last;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  // Trial code presented after k decisions: binary search toward target.
  function automatic logic [NB-1:0] trial_code(input logic [NB-1:0] target, input int k);
    logic [NB-1:0] c;
    logic [NB-1:0] t;
    c = '0;
    for (int b = NB - 1; b > NB - 1 - k; b--) begin
      t = c | (NB'(1) << b);
      if (target >= t) c = t;
    end
    return c | (NB'(1) << (NB - 1 - k));
  endfunction

  // Monitor: pop an expectation for every result_valid pulse.
  always @(negedge clock) begin
    exp_t e;
    if (reset_ && result_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual=pulse result=%0h chan=%0d expected=no pulse (cycle %0d)",
                 result, result_chan, cyc);
      end else begin
        e = sb.pop_front();
        check("result", int'(result), int'(e.res));
        check("result_chan", int'(result_chan), int'(e.ch));
        check("valid_cycle", cyc, e.t);
        check("eoc_at_valid", int'(eoc), int'(e.last));
      end
    end
  end

  // Issue one conversion/scan, push expectations, wait for the scoreboard to drain.
  task automatic do_conv(input bit scan_v, input logic [1:0] chan_v, input bit hold, input int drop_after);
    int t0;
    int i;
    bit done;
    soc = 1'b1;
    scan = scan_v;
    chan_sel = chan_v;
    t0 = cyc + 1;
    if (!scan_v) begin
      sb.push_back('{tgt[chan_v], chan_v, t0 + NB * (S + 1), 1'b1});
    end else begin
      for (int k = 0; k < CH; k++)
        sb.push_back('{tgt[k], 2'(k), t0 + (k + 1) * NB * (S + 1), (k == CH - 1)});
    end
    step();
    i = 0;
    done = 1'b0;
    while (!done && i < 400) begin
      if (i == 0) begin
        check("mux_sel_start", int'(mux_sel), scan_v ? 0 : int'(chan_v));
        check("eoc_converting", int'(eoc), 0);
      end
      if (!scan_v && (i % (S + 1)) == 0 && (i / (S + 1)) < NB)
        check("dac_code", int'(dac_code), int'(trial_code(tgt[chan_v], i / (S + 1))));
      if (!hold && i == drop_after) soc = 1'b0;
      if (sb.size() == 0) done = 1'b1;
      else begin
        step();
        i++;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL conv_timeout actual=%0d pending expected=0 pending", sb.size());
      sb.delete();
    end
    if (!hold) begin
      soc = 1'b0;
      step();
    end
  endtask

  // Wide DUT: digit is correct only on the edge that samples it.
  task automatic run2(input logic [1:0] chan_v, input logic [N2-1:0] target);
    int i;
    bit seen;
    logic [1:0] ch;
    ch = (chan_v >= 2'(CH2)) ? 2'(CH2 - 1) : chan_v;
    tgt2[ch] = target;
    soc2 = 1'b1;
    scan2 = 1'b0;
    chan2 = chan_v;
    step();
    soc2 = 1'b0;
    i = 0;
    seen = 1'b0;
    digit2 = ~(tgt2[mux2] >= dac2);
    while (!seen && i < 80) begin
      step();
      i++;
      if (rv2) begin
        seen = 1'b1;
        check("w_valid_cycle", i, N2 * (S2 + 1));
        check("w_result", int'(res2), int'(target));
        check("w_result_chan", int'(rch2), int'(ch));
        check("w_eoc", int'(eoc2), 1);
      end else begin
        if (((i + 1) % (S2 + 1)) == 0) digit2 = (tgt2[mux2] >= dac2);
        else digit2 = ~(tgt2[mux2] >= dac2);
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL w_timeout actual=no pulse expected=pulse at %0d", N2 * (S2 + 1));
    end
    step();
    step();
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] c;
    bit sv;
    for (int k = 0; k < CH; k++) tgt[k] = '0;
    for (int k = 0; k < CH2; k++) tgt2[k] = '0;

    reset_ = 1'b0;
    repeat (3) step();
    check("rst_dac_code", int'(dac_code), 0);
    check("rst_mux_sel", int'(mux_sel), 0);
    check("rst_eoc", int'(eoc), 1);
    check("rst_result", int'(result), 0);
    check("rst_result_chan", int'(result_chan), 0);
    check("rst_result_valid", int'(result_valid), 0);
    check("rst_eoc2", int'(eoc2), 1);
    reset_ = 1'b1;
    step();

    tgt[0] = 8'h11; tgt[1] = 8'h22; tgt[2] = 8'hA5; tgt[3] = 8'h33;
    do_conv(1'b0, 2'd2, 1'b0, 0);
    check("result_held", int'(result), 8'hA5);

    tgt[1] = 8'h00;
    do_conv(1'b0, 2'd1, 1'b0, 0);
    tgt[3] = 8'hFF;
    do_conv(1'b0, 2'd3, 1'b0, 0);

    tgt[0] = 8'h12; tgt[1] = 8'h80; tgt[2] = 8'hFF; tgt[3] = 8'h00;
    do_conv(1'b1, 2'd2, 1'b0, 0);

    tgt[0] = 8'($urandom);
    do_conv(1'b0, 2'd0, 1'b0, 5);

    tgt[1] = 8'h5C;
    do_conv(1'b0, 2'd1, 1'b1, 0);
    repeat (5) begin
      step();
      check("eoc_held_done", int'(eoc), 1);
    end
    soc = 1'b0;
    step();
    tgt[1] = 8'hC3;
    do_conv(1'b0, 2'd1, 1'b0, 0);

    soc = 1'b1; scan = 1'b0; chan_sel = 2'd2;
    step();
    soc = 1'b0;
    repeat (6) step();
    sb.delete();
    reset_ = 1'b0;
    step();
    check("midrst_eoc", int'(eoc), 1);
    check("midrst_dac_code", int'(dac_code), 0);
    check("midrst_result", int'(result), 0);
    check("midrst_valid", int'(result_valid), 0);
    reset_ = 1'b1;
    step();
    tgt[2] = 8'h6B;
    do_conv(1'b0, 2'd2, 1'b0, 0);

    for (int n = 0; n < 12; n++) begin
      for (int k = 0; k < CH; k++) tgt[k] = 8'($urandom);
      sv = ($urandom_range(0, 3) == 0);
      c = 2'($urandom_range(0, 3));
      do_conv(sv, c, 1'b0, $urandom_range(0, 20));
    end

    run2(2'd0, 10'h2AA);
    run2(2'd3, 10'($urandom));
    run2(2'd1, 10'h3FF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sar_adc_controller.md
# sar_adc_controller

Parametrised successive-approximation register controller for the team's ADC front end. It generalises the fixed 8-bit, single-input SAR to N bits, a configurable comparator settle time, and a multi-channel input multiplexer with single-channel and scan modes. It drives the DAC code and the analog mux select, samples the external comparator, and returns results through the existing soc/eoc handshake plus a per-result valid strobe.

## Interface
- N, default 8: conversion width in bits, range 2..16.
- CHANNELS, default 4: number of analog inputs, range 1..16.
- SETTLE, default 1: wait cycles after each DAC update before the comparator is sampled, range 0..15.
- CW, derived as max(1, clog2(CHANNELS)): channel index width.

Ports:
- clock  in  1  the single clock; everything updates on the rising edge.
- reset_  in  1  synchronous, active-low reset, sampled on the rising edge of clock.
- soc  in  1  start of conversion; level-sensitive.
- scan  in  1  mode select, sampled together with soc: 0 = single channel, 1 = scan all channels.
- chan_sel  in  CW  channel used in single mode, sampled together with soc.
- digit  in  1  comparator output: 1 means the analog input is greater than or equal to the DAC output.
- dac_code  out  N  trial code driven to the DAC.
- mux_sel  out  CW  analog mux select.
- eoc  out  1  end of conversion: 1 when idle or done, 0 while converting.
- result  out  N  last completed conversion; held until overwritten.
- result_chan  out  CW  channel of `result`.
- result_valid  out  1  one-cycle pulse per completed channel conversion.

## Operation
- States:
  - IDLE: eoc=1. When soc=1, latch scan and chan_sel, go to CONV, set dac_code to MSB-only (1 followed by N-1 zeros), set mux_sel to the start channel, eoc←0, bit index←N-1, wait←SETTLE.
  - CONV: if wait>0, decrement wait. Otherwise do the decide step:
    - code[index]←digit;
    - if index>0, set code[index-1]←1, decrement index, wait←SETTLE;
    - if index==0, the channel is complete (see below).
  - DONE: eoc=1. When soc=0, go to IDLE. While soc=1, stay in DONE.
- Start channel:
  - Single mode: chan_sel.
  - Scan mode: channel 0.
  - A chan_sel ≥ CHANNELS is clamped to CHANNELS-1.
- Channel complete:
  - On the completing edge: result←final code, result_chan←mux_sel, result_valid←1 for that cycle.
  - Single mode, or scan mode on the last channel: go to DONE, eoc←1.
  - Scan mode with more channels left: in the same edge, mux_sel increments, dac_code←MSB-only, index←N-1, wait←SETTLE. eoc stays 0.
- soc, scan and chan_sel are ignored outside IDLE. Dropping soc mid-conversion does not abort the conversion.
- Bits that have already been decided never change. The bit being tried is 1; bits below it are 0.

## Timing
- Reset values:
  - State IDLE.
  - dac_code=0, mux_sel=0, eoc=1.
  - result=0, result_chan=0, result_valid=0.
  - Index and wait counters are cleared.
- Reset asserted during CONV or DONE: all of the above takes effect at the next edge. No result_valid pulse is issued.
- Per-bit cost is SETTLE+1 cycles. The comparator is sampled exactly SETTLE+1 edges after the corresponding dac_code change.
- Single-mode latency: eoc rises and result_valid pulses N·(SETTLE+1) edges after the edge that sampled soc=1.
  - N=8, SETTLE=1: 16 cycles.
- Scan-mode latency: result_valid pulses at k·N·(SETTLE+1) for k=1..CHANNELS. eoc rises together with the last pulse.
- Minimum restart: one DONE cycle with soc=0, one IDLE cycle, then soc=1 is accepted.
- soc held at 1 continuously: exactly one conversion or scan, then the block stays in DONE.

## Structure
- Package sar_pkg holds:
  - the state encoding (IDLE, CONV, DONE);
  - the CW derivation function;
  - parameter range limits.
- Sub-module sar_core holds the single-channel N-bit approximation engine:
  - code register, bit index, settle counter, and the decide step;
  - interface: start / done / code.
- The top level adds channel sequencing, the mode latch, the soc/eoc handshake and the result registers.

## Test plan
The comparator model drives digit = (target[channel] ≥ dac_code). Default parameters unless stated.
- Single mode, chan_sel=2, target 8'hA5 → at edge 16 after soc: result=8'hA5, result_chan=2, result_valid pulses once, eoc=1; dac_code sequence starts 80, C0, A0, B0, A8, A4, A6, A5.
- Single mode, targets 8'h00 and 8'hFF → results 8'h00 and 8'hFF. No wrap or overflow in dac_code.
- Scan mode, targets {12,80,FF,00} → four result_valid pulses at cycles 16/32/48/64 with result_chan 0..3 and the matching results; eoc stays low until cycle 64.
- SETTLE=3, N=10, target 10'h2AA → result 10'h2AA at cycle 40; digit is sampled exactly 4 edges after each dac_code change (checked by toggling digit outside the sampling window).
- reset_=0 at cycle 7 of a conversion → next edge: eoc=1, dac_code=0, result=0, no valid pulse. A fresh soc then converts correctly.
- soc dropped at cycle 5 → conversion still completes at 16. soc held high → block stays in DONE; after soc low for one cycle and soc high again, a second conversion is accepted.
